// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter granting one crossbar slave to one of N_MASTERS masters per session.
// Optional forced release after TIMEOUT cycles is enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_slave_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255,
  localparam int IDX_W    = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 session_finished,
  output logic [N_MASTERS-1:0] grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_pulse
);

  // Handshake: grant/grant_valid/grant_idx change only at a session boundary; the
  // granted master owns the slave until session_finished (or a forced release) is sampled.

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] next_idx;
  logic             timeout_hit;
  logic             release_now;

  if (N_MASTERS < 2 || N_MASTERS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_out_of_range
  end

  // First requester strictly after base, wrapping; base itself is checked last.
  function automatic logic [IDX_W-1:0] pick_next(input logic [N_MASTERS-1:0] r,
                                                 input logic [IDX_W-1:0]     base);
    logic [IDX_W-1:0] res;
    logic             found;
    int               j;
    res   = base;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      j = (int'(base) + k) % N_MASTERS;
      if (!found && r[j]) begin
        found = 1'b1;
        res   = IDX_W'(j);
      end
    end
    return res;
  endfunction

  assign search_base = (state == IDLE) ? last_idx : grant_idx;
  assign next_idx    = pick_next(req, search_base);
  assign release_now = (state == GRANTED) && (session_finished || timeout_hit);

`ifdef XBAR_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
  assign timeout_hit = (state == GRANTED) && (hold_cnt == 16'(TIMEOUT - 1));
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_idx    <= IDX_W'(N_MASTERS - 1);
`ifdef XBAR_ARB_TIMEOUT_EN
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= GRANTED;
            grant       <= N_MASTERS'(1) << next_idx;
            grant_valid <= 1'b1;
            grant_idx   <= next_idx;
`ifdef XBAR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANTED: begin
          if (release_now) begin
            last_idx <= grant_idx;
`ifdef XBAR_ARB_TIMEOUT_EN
            timeout_pulse <= !session_finished;
            hold_cnt      <= '0;
`endif
            if (|req) begin
              grant     <= N_MASTERS'(1) << next_idx;
              grant_idx <= next_idx;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
            end
          end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed-vector bench for xbar_slave_arbiter (N_MASTERS=4, TIMEOUT=8).
// Timeout vectors are selected by XBAR_ARB_TIMEOUT_EN, matching the RTL build.
module tb_xbar_slave_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         session_finished;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         timeout_pulse;

  int vectors;
  int miscompares;

  xbar_slave_arbiter #(.N_MASTERS(N), .TIMEOUT(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .session_finished (session_finished),
    .grant            (grant),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .timeout_pulse    (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [N-1:0] exp_grant, input logic [1:0] exp_idx);
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check({tag, ".valid"}, 32'(grant_valid), 32'(exp_grant != '0));
    check({tag, ".idx"}, 32'(grant_idx), 32'(exp_idx));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_pulse;
    session_finished = 1'b1;
    tick();
    session_finished = 1'b0;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    req              = '0;
    session_finished = 1'b0;
    tick();
    tick();
    chk_grant("reset", 4'b0000, 2'd0);
    check("reset.timeout_pulse", 32'(timeout_pulse), 32'd0);

    // Master 0 has first priority after reset; 1010 -> master 1
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk_grant("first_grant", 4'b0010, 2'd1);

    // Rotation with all requesting, including wrap
    req = 4'b1111;
    tick();
    chk_grant("hold_m1", 4'b0010, 2'd1);
    finish_pulse();
    chk_grant("rr_m2", 4'b0100, 2'd2);
    tick();
    finish_pulse();
    chk_grant("rr_m3", 4'b1000, 2'd3);
    finish_pulse();
    chk_grant("rr_wrap_m0", 4'b0001, 2'd0);

    // Grant to master 2, then its request drops: grant held until finish
    req = 4'b0100;
    finish_pulse();
    chk_grant("m2_grant", 4'b0100, 2'd2);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_grant($sformatf("m2_hold_%0d", i), 4'b0100, 2'd2);
    end
    finish_pulse();
    chk_grant("m2_release_idle", 4'b0000, 2'd0);
    finish_pulse();
    chk_grant("idle_ignores_finish", 4'b0000, 2'd0);

    // Sole requester re-granted back-to-back with no idle gap
    req = 4'b1000;
    tick();
    chk_grant("m3_grant", 4'b1000, 2'd3);
    for (int i = 0; i < 3; i++) begin
      finish_pulse();
      chk_grant($sformatf("m3_regrant_%0d", i), 4'b1000, 2'd3);
    end

    // Fairness: the finishing master loses to any other requester
    req = 4'b1001;
    finish_pulse();
    chk_grant("fair_m0", 4'b0001, 2'd0);
    finish_pulse();
    chk_grant("fair_m3", 4'b1000, 2'd3);
    req = 4'b0000;
    finish_pulse();
    chk_grant("fair_idle", 4'b0000, 2'd0);
    check("no_pulse_default", 32'(timeout_pulse), 32'd0);

`ifdef XBAR_ARB_TIMEOUT_EN
    // Forced release 8 cycles after the grant edge, one-cycle pulse
    req = 4'b0001;
    tick();
    chk_grant("to_grant", 4'b0001, 2'd0);
    req = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_grant($sformatf("to_hold_%0d", i), 4'b0001, 2'd0);
      check($sformatf("to_nopulse_%0d", i), 32'(timeout_pulse), 32'd0);
    end
    tick();
    chk_grant("to_release", 4'b0000, 2'd0);
    check("to_pulse", 32'(timeout_pulse), 32'd1);
    tick();
    check("to_pulse_end", 32'(timeout_pulse), 32'd0);

    // Finish on the timeout cycle wins: normal release, no pulse
    req = 4'b0001;
    tick();
    chk_grant("tof_grant", 4'b0001, 2'd0);
    req = 4'b0000;
    for (int i = 1; i < 8; i++) tick();
    finish_pulse();
    chk_grant("tof_release", 4'b0000, 2'd0);
    check("tof_nopulse", 32'(timeout_pulse), 32'd0);
    tick();
    check("tof_nopulse2", 32'(timeout_pulse), 32'd0);
`else
    // Without forced release the grant is held indefinitely
    req = 4'b0001;
    tick();
    chk_grant("nto_grant", 4'b0001, 2'd0);
    req = 4'b0000;
    for (int i = 0; i < 20; i++) tick();
    chk_grant("nto_hold", 4'b0001, 2'd0);
    check("nto_nopulse", 32'(timeout_pulse), 32'd0);
    finish_pulse();
    chk_grant("nto_release", 4'b0000, 2'd0);
`endif

    // Asynchronous reset mid-cycle drops grant before the next edge
    req = 4'b0100;
    tick();
    chk_grant("ar_grant", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_grant("ar_async_drop", 4'b0000, 2'd0);
    tick();
    req   = 4'b1100;
    rst_n = 1'b1;
    tick();
    chk_grant("ar_after_release", 4'b0100, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
